car_row_scheduler: RTL and testbench
====================================

Name: car_row_scheduler

Overview:
- Builds, one grid row ahead, a per-column sprite map from the 16 car slot positions, so the VGA pixel path does one table read per 32-px cell instead of 16 parallel coordinate compares.
- Sits between the game-state car registers and the VGA display pixel mux.
- Double-buffered: the display reads the active bank while this block fills the shadow bank for the next row.

Parameters:
- NUM_CARS, 16, number of car slots scanned (fixed bus widths assume 16)
- NUM_COLS, 20, visible grid columns (640/32)
- CAR_TYPE, 32'h0000_0000, 2 bits per car i at [2i+1:2i]: 0 blue-left, 1 blue-right, 2 red-left, 3 red-right

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- car_x_flat  in  80  car i column at [5i+4:5i]
- car_y_flat  in  64  car i row at [4i+3:4i]
- row_load  in  1  1-cycle strobe: start building map for load_row
- load_row  in  4  grid row to build, sampled on row_load
- row_swap  in  1  1-cycle strobe: shadow becomes active (issued at grid-row boundary)
- rd_col  in  5  display column lookup
- rd_type  out  3  0 none, 1 blue-left, 2 blue-right, 3 red-left, 4 red-right
- busy  out  1  CLEAR or SCAN in progress
- ready  out  1  shadow bank complete, awaiting swap
- late  out  1  1-cycle pulse: row_swap arrived while not ready
- overlap  out  1  sticky until next row_load: two cars mapped to one column in the built row

Behaviour:
- Storage: 2 banks × NUM_COLS × 3 bits, plus bank_sel register and active_valid flag.
- Reset:
  - rd_type=0, busy=0, ready=0, late=0, overlap=0.
  - bank_sel=0, active_valid=0, state=IDLE.
  - While active_valid=0, rd_type reads 0 regardless of table contents.
- FSM:
  - IDLE: on row_load, latch load_row into tgt_row, clear overlap, go to CLEAR with idx=0.
  - CLEAR: write 0 to shadow[idx]; idx 0..NUM_COLS-1, one per cycle (20 cycles). Then SCAN with idx=0.
  - SCAN: one car per cycle, idx 0..15 (16 cycles).
    - If car_y==tgt_row and car_x<NUM_COLS, write CAR_TYPE[i]+1 to shadow[car_x].
    - If that entry is already nonzero, keep the existing value (lowest index wins) and set overlap.
    - Car positions are sampled live during SCAN; the game updates them only at frame rate.
    - After idx 15, go to READY.
  - READY: ready=1. Hold until row_swap or row_load.
- busy=1 in CLEAR and SCAN. Load-to-ready latency is 36 cycles after the row_load cycle, well inside one 800-cycle line.
- row_swap:
  - In READY: toggle bank_sel, set active_valid=1, go to IDLE, ready=0.
  - In any other state: bank_sel unchanged, active contents retained, late pulses for 1 cycle.
- row_load while busy: abort and restart at CLEAR with the new load_row. Overlap is cleared.
- row_load in READY: discard the pending shadow and restart at CLEAR. No swap occurs.
- Simultaneous row_swap and row_load: evaluate the swap first against the current state, then start the load into the new shadow bank.
  - In READY, the swap succeeds and the new build targets the just-freed bank.
- Read path:
  - rd_type is registered, 1-cycle latency from rd_col.
  - Reads the active bank, combined with the swap effective in the same cycle (the read uses the pre-swap bank_sel).
  - rd_col >= NUM_COLS returns 0.
- Reset mid-operation returns to the reset state next cycle; partial shadow contents are discarded.

Test Plan:
1. Reset, then sweep rd_col 0..19 → rd_type=0 on every read; busy=0, ready=0.
2. CAR_TYPE=32'hE4 (car0 blue-left, car1 blue-right, car2 red-left, car3 red-right); cars 0..3 at (x=2,5,7,19) on row 3, others at row 9. row_load with load_row=3 → ready rises after exactly 36 cycles. row_swap, then read cols 2,5,7,19 → 1,2,3,4; all other columns → 0.
3. Cars 4 and 9 both at (x=10, y=6), types blue-right and red-left; build row 6 → col 10 reads 2, overlap=1. Next row_load clears overlap.
4. row_swap 10 cycles after row_load → late pulses once; rd_type still shows the previous row's map. Build then completes and ready=1.
5. Second row_load at cycle 20 of a build (load_row changes 3→4) → ready at 36 cycles after the second strobe; map reflects row 4 only.
6. Car with x=25 on target row → ignored, all columns 0. row_load and row_swap together while ready → swap is taken and the new build fills the other bank. Reset asserted mid-SCAN → all outputs at reset values next cycle.

Source files
------------

// File: rtl/car_row_if.sv
// Bus between the game-state/display side and car_row_scheduler.
//
// Strobe semantics: row_load and row_swap are single-cycle strobes sampled on
// the rising clock edge; there is no back-pressure. ready is a level that
// stays high until the next row_swap or row_load. rd_col -> rd_type is a
// fixed one-cycle read with no handshake. late is a one-cycle pulse.
interface car_row_if;
  logic [79:0] car_x_flat;
  logic [63:0] car_y_flat;
  logic        row_load;
  logic [3:0]  load_row;
  logic        row_swap;
  logic [4:0]  rd_col;
  logic [2:0]  rd_type;
  logic        busy;
  logic        ready;
  logic        late;
  logic        overlap;
  logic [1:0]  dbg_state;

  modport master (
    output car_x_flat, car_y_flat, row_load, load_row, row_swap, rd_col,
    input  rd_type, busy, ready, late, overlap, dbg_state
  );

  modport slave (
    input  car_x_flat, car_y_flat, row_load, load_row, row_swap, rd_col,
    output rd_type, busy, ready, late, overlap, dbg_state
  );
endinterface

// File: rtl/car_row_scheduler.sv
// Builds a per-column sprite map for one grid row from the car slot positions
// into a shadow bank while the display reads the active bank. A build clears
// the shadow bank one column per cycle, then scans one car per cycle.
module car_row_scheduler #(
  parameter int          NUM_CARS = 16,
  parameter int          NUM_COLS = 20,
  parameter logic [31:0] CAR_TYPE = 32'h0000_0000
) (
  input logic       clk,
  input logic       reset,
  car_row_if.slave  bus
);

  localparam logic [4:0] LP_NUM_COLS = 5'(NUM_COLS);
  localparam logic [4:0] LP_LAST_COL = 5'(NUM_COLS - 1);
  localparam logic [4:0] LP_LAST_CAR = 5'(NUM_CARS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SCAN  = 2'd2,
    ST_READY = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [4:0]  r_idx;
  logic [4:0]  w_idx_next;
  logic [3:0]  r_tgt_row;
  logic        r_bank_sel;
  logic        r_active_valid;
  logic        r_late;
  logic        r_overlap;
  logic [2:0]  r_rd_type;

  // Bank r_bank_sel is the one the display reads; the other is the shadow.
  logic [2:0]  r_bank0 [NUM_COLS];
  logic [2:0]  r_bank1 [NUM_COLS];

  logic        w_load;
  logic        w_swap_ok;
  logic        w_late_next;
  logic        w_ovl_set;
  logic        w_we;
  logic [4:0]  w_waddr;
  logic [2:0]  w_wdata;

  logic [3:0]  w_car_i;
  logic [4:0]  w_car_x;
  logic [3:0]  w_car_y;
  logic [1:0]  w_car_kind;
  logic [2:0]  w_type_code;
  logic        w_car_hit;
  logic [4:0]  w_sh_addr;
  logic [2:0]  w_sh_entry;

  logic        w_rd_in_range;
  logic [4:0]  w_rd_addr;
  logic [2:0]  w_rd_value;

  // Select the car being scanned this cycle and look up its shadow column.
  always_comb begin
    w_car_i     = r_idx[3:0];
    w_car_x     = bus.car_x_flat[5*w_car_i +: 5];
    w_car_y     = bus.car_y_flat[4*w_car_i +: 4];
    w_car_kind  = CAR_TYPE[2*w_car_i +: 2];
    w_type_code = {1'b0, w_car_kind} + 3'd1;
    w_car_hit   = (w_car_y == r_tgt_row) && (w_car_x < LP_NUM_COLS);
    w_sh_addr   = (w_car_x < LP_NUM_COLS) ? w_car_x : 5'd0;
    w_sh_entry  = r_bank_sel ? r_bank0[w_sh_addr] : r_bank1[w_sh_addr];
  end

  // Next-state and shadow-write control; a row_load always restarts a build.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_load       = 1'b0;
    w_swap_ok    = 1'b0;
    w_late_next  = 1'b0;
    w_ovl_set    = 1'b0;
    w_we         = 1'b0;
    w_waddr      = 5'd0;
    w_wdata      = 3'd0;

    // The swap is judged against the current state before any load.
    if (bus.row_swap) begin
      if (r_state == ST_READY) w_swap_ok = 1'b1;
      else                     w_late_next = 1'b1;
    end

    case (r_state)
      ST_IDLE: begin
        w_state_next = ST_IDLE;
      end
      ST_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_idx;
        w_wdata = 3'd0;
        if (r_idx == LP_LAST_COL) begin
          w_state_next = ST_SCAN;
          w_idx_next   = 5'd0;
        end else begin
          w_idx_next = r_idx + 5'd1;
        end
      end
      ST_SCAN: begin
        if (w_car_hit) begin
          // Lowest car index keeps the column; later hits only flag overlap.
          if (w_sh_entry != 3'd0) begin
            w_ovl_set = 1'b1;
          end else begin
            w_we    = 1'b1;
            w_waddr = w_car_x;
            w_wdata = w_type_code;
          end
        end
        if (r_idx == LP_LAST_CAR) begin
          w_state_next = ST_READY;
          w_idx_next   = 5'd0;
        end else begin
          w_idx_next = r_idx + 5'd1;
        end
      end
      ST_READY: begin
        if (w_swap_ok) w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_idx_next   = 5'd0;
      end
    endcase

    if (bus.row_load) begin
      w_load       = 1'b1;
      w_state_next = ST_CLEAR;
      w_idx_next   = 5'd0;
      w_we         = 1'b0;
      w_ovl_set    = 1'b0;
    end
  end

  // State, control registers and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_idx          <= 5'd0;
      r_tgt_row      <= 4'd0;
      r_bank_sel     <= 1'b0;
      r_active_valid <= 1'b0;
      r_late         <= 1'b0;
      r_overlap      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_late  <= w_late_next;
      if (w_load) r_tgt_row <= bus.load_row;
      if (w_swap_ok) begin
        r_bank_sel     <= ~r_bank_sel;
        r_active_valid <= 1'b1;
      end
      if (w_load)         r_overlap <= 1'b0;
      else if (w_ovl_set) r_overlap <= 1'b1;
    end
  end

  // Shadow bank write port; the shadow is the bank not selected for display.
  always_ff @(posedge clk) begin
    if (!reset && w_we) begin
      if (r_bank_sel) r_bank0[w_waddr] <= w_wdata;
      else            r_bank1[w_waddr] <= w_wdata;
    end
  end

  // Display read: uses the bank selection as it stood before any same-cycle swap.
  always_comb begin
    w_rd_in_range = (bus.rd_col < LP_NUM_COLS);
    w_rd_addr     = w_rd_in_range ? bus.rd_col : 5'd0;
    if (r_active_valid && w_rd_in_range)
      w_rd_value = r_bank_sel ? r_bank1[w_rd_addr] : r_bank0[w_rd_addr];
    else
      w_rd_value = 3'd0;
  end

  // Registered read result, one cycle after rd_col.
  always_ff @(posedge clk) begin
    if (reset) r_rd_type <= 3'd0;
    else       r_rd_type <= w_rd_value;
  end

  assign bus.rd_type   = r_rd_type;
  assign bus.busy      = (r_state == ST_CLEAR) || (r_state == ST_SCAN);
  assign bus.ready     = (r_state == ST_READY);
  assign bus.late      = r_late;
  assign bus.overlap   = r_overlap;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_car_row_scheduler.sv
// Bench for car_row_scheduler: random car layouts checked against a
// row-map reference model; read responses are checked through an expected queue.
module tb_car_row_scheduler;

  localparam logic [31:0] TB_CAR_TYPE = 32'h0008_01E4;

  logic clk;
  logic reset;
  car_row_if bus ();

  car_row_scheduler #(
    .NUM_CARS (16),
    .NUM_COLS (20),
    .CAR_TYPE (TB_CAR_TYPE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // ---------------- car positions ----------------
  logic [4:0] car_x [16];
  logic [3:0] car_y [16];

  always_comb begin
    bus.car_x_flat = '0;
    bus.car_y_flat = '0;
    for (int i = 0; i < 16; i++) begin
      bus.car_x_flat[5*i +: 5] = car_x[i];
      bus.car_y_flat[4*i +: 4] = car_y[i];
    end
  end

  // ---------------- reference model ----------------
  int unsigned act_map [20];
  int unsigned shd_map [20];
  bit          act_valid;
  bit          shd_ovl;
  bit          m_ready;
  int unsigned m_row;

  function automatic void build_model(input int unsigned row);
    shd_ovl = 1'b0;
    for (int c = 0; c < 20; c++) shd_map[c] = 0;
    for (int i = 0; i < 16; i++) begin
      if (car_y[i] == row && car_x[i] < 20) begin
        if (shd_map[car_x[i]] != 0) shd_ovl = 1'b1;
        else shd_map[car_x[i]] = ((TB_CAR_TYPE >> (2*i)) & 32'd3) + 1;
      end
    end
  endfunction

  function automatic int unsigned exp_rd(input int unsigned col);
    if (act_valid && col < 20) return act_map[col];
    return 0;
  endfunction

  // ---------------- scoreboard ----------------
  logic [2:0] exp_q [$];
  logic       rd_issue;
  logic       rd_vld_d;
  int         pass_cnt;
  int         total_cnt;

  always @(posedge clk) rd_vld_d <= rd_issue;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic monitor();
    logic [2:0] e;
    forever begin
      @(negedge clk);
      if (rd_vld_d) begin
        if (exp_q.size() == 0) begin
          check("rd_type_unexpected", int'(bus.rd_type), -1);
        end else begin
          e = exp_q.pop_front();
          check("rd_type", int'(bus.rd_type), int'(e));
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    bus.row_load = 1'b0;
    bus.row_swap = 1'b0;
    rd_issue     = 1'b0;
  endtask

  task automatic read_col(input int unsigned c);
    bus.rd_col = 5'(c);
    exp_q.push_back(3'(exp_rd(c)));
    rd_issue = 1'b1;
    step();
  endtask

  task automatic sweep();
    for (int c = 0; c < 32; c++) read_col(c);
  endtask

  task automatic load(input int unsigned row);
    bus.load_row = 4'(row);
    bus.row_load = 1'b1;
    step();
    m_ready = 1'b0;
    m_row   = row;
    check("busy_after_load", int'(bus.busy), 1);
    check("overlap_cleared", int'(bus.overlap), 0);
  endtask

  task automatic swap();
    bit was_ready;
    was_ready = m_ready;
    bus.row_swap = 1'b1;
    step();
    if (was_ready) begin
      for (int c = 0; c < 20; c++) act_map[c] = shd_map[c];
      act_valid = 1'b1;
      m_ready   = 1'b0;
    end
    check("late_on_swap", int'(bus.late), was_ready ? 0 : 1);
    if (was_ready) check("ready_after_swap", int'(bus.ready), 0);
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!bus.ready && cnt < 200) begin
      step();
      cnt++;
    end
    check("ready_reached", int'(bus.ready), 1);
    build_model(m_row);
    m_ready = 1'b1;
    check("overlap", int'(bus.overlap), int'(shd_ovl));
    check("busy_when_ready", int'(bus.busy), 0);
  endtask

  task automatic scatter(input int unsigned y_lo, input int unsigned y_hi);
    for (int i = 0; i < 16; i++) begin
      car_x[i] = 5'($urandom_range(0, 31));
      car_y[i] = 4'($urandom_range(y_lo, y_hi));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    bit was_ready;
    pass_cnt = 0;
    total_cnt = 0;
    reset = 1'b1;
    rd_issue = 1'b0;
    bus.row_load = 1'b0;
    bus.row_swap = 1'b0;
    bus.load_row = 4'd0;
    bus.rd_col = 5'd0;
    act_valid = 1'b0;
    m_ready = 1'b0;
    m_row = 0;
    scatter(9, 9);
    fork
      monitor();
    join_none

    // 1: reset state and empty reads
    repeat (3) step();
    check("rst_busy", int'(bus.busy), 0);
    check("rst_ready", int'(bus.ready), 0);
    check("rst_late", int'(bus.late), 0);
    check("rst_overlap", int'(bus.overlap), 0);
    check("rst_rd_type", int'(bus.rd_type), 0);
    check("rst_state", int'(bus.dbg_state), 0);
    reset = 1'b0;
    step();
    sweep();
    swap();
    step();
    check("late_one_cycle", int'(bus.late), 0);

    // 2: four car types on row 3
    scatter(9, 9);
    car_x[0] = 5'd2;  car_y[0] = 4'd3;
    car_x[1] = 5'd5;  car_y[1] = 4'd3;
    car_x[2] = 5'd7;  car_y[2] = 4'd3;
    car_x[3] = 5'd19; car_y[3] = 4'd3;
    load(3);
    wait_ready(lat);
    check("latency_row3", lat, 36);
    swap();
    sweep();

    // 3: two cars on one column
    scatter(9, 9);
    car_x[4] = 5'd10; car_y[4] = 4'd6;
    car_x[9] = 5'd10; car_y[9] = 4'd6;
    load(6);
    wait_ready(lat);
    check("latency_row6", lat, 36);
    check("overlap_set", int'(bus.overlap), 1);
    swap();
    read_col(10);

    // 4: early swap while building (load also clears overlap)
    scatter(0, 3);
    load(2);
    repeat (9) step();
    swap();
    step();
    check("late_pulse_end", int'(bus.late), 0);
    sweep();
    wait_ready(lat);
    swap();
    sweep();

    // 5: reload mid-build switches the target row
    scatter(9, 9);
    for (int i = 0; i < 4; i++) begin
      car_x[i] = 5'($urandom_range(0, 19));
      car_y[i] = 4'd3;
    end
    for (int i = 5; i < 9; i++) begin
      car_x[i] = 5'($urandom_range(0, 19));
      car_y[i] = 4'd4;
    end
    load(3);
    repeat (19) step();
    load(4);
    wait_ready(lat);
    check("latency_reload", lat, 36);
    swap();
    sweep();

    // 6a: off-grid car is ignored
    scatter(9, 9);
    car_x[0] = 5'd25; car_y[0] = 4'd7;
    load(7);
    wait_ready(lat);
    swap();
    sweep();

    // 6b: swap and load together in READY, with a same-cycle read
    scatter(1, 2);
    load(1);
    wait_ready(lat);
    bus.rd_col = 5'd3;
    exp_q.push_back(3'(exp_rd(3)));
    rd_issue = 1'b1;
    bus.row_swap = 1'b1;
    bus.load_row = 4'd2;
    bus.row_load = 1'b1;
    step();
    for (int c = 0; c < 20; c++) act_map[c] = shd_map[c];
    act_valid = 1'b1;
    m_ready = 1'b0;
    m_row = 2;
    check("late_combined", int'(bus.late), 0);
    check("busy_combined", int'(bus.busy), 1);
    sweep();
    wait_ready(lat);
    swap();
    sweep();

    // randomized builds
    for (int it = 0; it < 6; it++) begin
      scatter(0, 3);
      load($urandom_range(0, 3));
      wait_ready(lat);
      check("latency_rand", lat, 36);
      was_ready = ($urandom_range(0, 1) == 1);
      if (was_ready) begin
        swap();
        sweep();
      end
    end

    // 6c: reset in the middle of SCAN
    scatter(0, 3);
    load(1);
    repeat (25) step();
    check("in_scan", int'(bus.dbg_state), 2);
    reset = 1'b1;
    step();
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_ready", int'(bus.ready), 0);
    check("midrst_late", int'(bus.late), 0);
    check("midrst_overlap", int'(bus.overlap), 0);
    check("midrst_rd_type", int'(bus.rd_type), 0);
    check("midrst_state", int'(bus.dbg_state), 0);
    reset = 1'b0;
    act_valid = 1'b0;
    m_ready = 1'b0;
    sweep();

    repeat (3) step();
    check("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
